merge_rr_sched: RTL and testbench

- N-input round-robin read scheduler that merges spike-event words from several input FIFOs into one output FIFO.
- Sits between the per-core event buffers and the shared event bus buffer; replaces fixed-priority merging so no source starves.
- Supports bounded bursts: a granted port may drain up to BURST_LEN consecutive words before the grant rotates.

---
 rtl/merge_rr_sched_pkg.sv | 22 ++
 rtl/merge_rr_sched_if.sv | 30 +++
 rtl/merge_rr_sched_rr_pick.sv | 29 ++
 rtl/merge_rr_sched.sv | 136 +++++++++++++
 tb/tb_merge_rr_sched.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/merge_rr_sched_pkg.sv
// Shared types and sizing helpers for the round-robin event merge scheduler.
package merge_sched_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_PORTS_DEF  = 4;
  localparam int unsigned BURST_LEN_DEF  = 4;

  // Burst counter holds 1..15.
  localparam int unsigned BURST_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    NEXT  = 2'd3
  } sched_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/merge_rr_sched_if.sv
// Input-FIFO / output-FIFO bundle seen by the merge scheduler.
interface merge_rr_sched_if
  import merge_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);

  logic [NUM_PORTS*DATA_WIDTH-1:0] din;
  logic [NUM_PORTS-1:0]            buf_empty;
  logic                            buffer_out_full;
  logic [NUM_PORTS-1:0]            read_en;
  logic [DATA_WIDTH-1:0]           dout;
  logic                            wen;
  logic [IDX_W-1:0]                grant_idx;
  logic                            busy;

  modport master (
    input  din, buf_empty, buffer_out_full,
    output read_en, dout, wen, grant_idx, busy
  );

  modport slave (
    output din, buf_empty, buffer_out_full,
    input  read_en, dout, wen, grant_idx, busy
  );

endinterface

// File: rtl/merge_rr_sched_rr_pick.sv
// Finds the first requesting port at or after ptr, wrapping past the last port.
module rr_pick
  import merge_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/merge_rr_sched.sv
// Round-robin merge of NUM_PORTS input event FIFOs into one output FIFO,
// with bounded bursts per grant and full-flag backpressure.
module merge_rr_sched
  import merge_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_PORTS  = NUM_PORTS_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input logic             clk,
  input logic             reset_n,
  merge_rr_sched_if.master bus
);

  localparam int unsigned IDX_W = idx_w(NUM_PORTS);
  localparam int unsigned CNT_W = BURST_CNT_W;
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]  read_en_q, read_en_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wen_q, wen_d;
  logic                  busy_q;

  logic [IDX_W-1:0]      ptr_inc, pick_ptr, pick_idx;
  logic                  pick_found;
  logic                  issue;
  logic [NUM_PORTS-1:0]  req;
  logic [DATA_WIDTH-1:0] din_sel;

  assign req      = ~bus.buf_empty;
  assign ptr_inc  = (grant_q == LAST_PORT) ? '0 : grant_q + IDX_W'(1);
  // At grant end the search starts just past the port that was granted.
  assign pick_ptr = (state_q == NEXT) ? ptr_inc : rr_ptr_q;
  assign din_sel  = bus.din[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    read_en_d = '0;
    dout_d    = dout_q;
    wen_d     = 1'b0;
    issue     = 1'b0;

    case (state_q)
      IDLE: issue = 1'b1;
      FETCH: begin
        // The read strobe is still out this cycle; its data lands next cycle.
        if (|read_en_q) begin
          state_d = FETCH;
        end else begin
          dout_d = din_sel;
          if (!bus.buffer_out_full) begin
            wen_d   = 1'b1;
            state_d = NEXT;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.buffer_out_full) begin
          wen_d   = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (!bus.buf_empty[grant_q] && (cnt_q < BURST_MAX) && !bus.buffer_out_full) begin
          read_en_d[grant_q] = 1'b1;
          cnt_d              = cnt_q + CNT_W'(1);
          state_d            = FETCH;
        end else begin
          rr_ptr_d = ptr_inc;
          issue    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      if (!bus.buffer_out_full && pick_found) begin
        grant_d             = pick_idx;
        cnt_d               = CNT_W'(1);
        read_en_d[pick_idx] = 1'b1;
        state_d             = FETCH;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      read_en_q <= '0;
      dout_q    <= '0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      read_en_q <= read_en_d;
      dout_q    <= dout_d;
      wen_q     <= wen_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.read_en   = read_en_q;
  assign bus.dout      = dout_q;
  assign bus.wen       = wen_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_merge_rr_sched.sv
// Directed bench for merge_rr_sched: FIFO models on the inputs, a write
// logger on the output, table-driven grant-order vectors plus corner cases.
module tb_merge_rr_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned NP = 4;
  localparam int unsigned BL = 4;
  localparam int LOGN = 512;

  logic clk = 1'b0;
  logic reset_n;
  logic full;
  logic fifo_clr;

  always #5 clk = ~clk;

  merge_rr_sched_if #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

  merge_rr_sched #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .BURST_LEN(BL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Input FIFO models: read data appears the cycle after a sampled read_en.
  logic [DW-1:0] mem [NP][16];
  int wr_p [NP];
  int rd_p [NP];
  logic [NP-1:0][DW-1:0] din_arr;
  logic [NP-1:0] empty_v;

  always_comb begin
    empty_v = '0;
    for (int i = 0; i < NP; i++) empty_v[i] = (rd_p[i] == wr_p[i]);
  end

  assign bus.din             = din_arr;
  assign bus.buf_empty       = empty_v;
  assign bus.buffer_out_full = full;

  always @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (fifo_clr) rd_p[i] <= 0;
      else if (bus.read_en[i] && rd_p[i] != wr_p[i]) begin
        din_arr[i] <= mem[i][rd_p[i] % 16];
        rd_p[i]    <= rd_p[i] + 1;
      end
    end
  end

  // Output-side logger, sampled just after each rising edge.
  int cyc, re_n, wl_n, onehot_err;
  int re_cyc [LOGN];
  int re_port [LOGN];
  int wl_cyc [LOGN];
  int wl_grant [LOGN];
  logic [DW-1:0] wl_data [LOGN];

  always @(posedge clk) begin
    #1;
    cyc++;
    if ($countones(bus.read_en) > 1) onehot_err++;
    if (|bus.read_en && re_n < LOGN) begin
      for (int i = 0; i < NP; i++) if (bus.read_en[i]) re_port[re_n] = i;
      re_cyc[re_n] = cyc;
      re_n++;
    end
    if (bus.wen && wl_n < LOGN) begin
      wl_cyc[wl_n]   = cyc;
      wl_data[wl_n]  = bus.dout;
      wl_grant[wl_n] = int'(bus.grant_idx);
      wl_n++;
    end
  end

  int n_cmp, n_bad;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int v, input int p, input int k);
    return 32'hE000_0000 | (32'(v) << 20) | (32'(p) << 16) | 32'(k);
  endfunction

  task automatic push(input int p, input logic [DW-1:0] d);
    mem[p][wr_p[p] % 16] = d;
    wr_p[p] = wr_p[p] + 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((bus.busy || bus.buf_empty != {NP{1'b1}}) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, 64'(n < 400), 64'd1);
  endtask

  task automatic wait_re(input int p, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.read_en[p]) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
  endtask

  typedef struct packed {
    logic [3:0][3:0]  cnt;
    logic [4:0]       exp_n;
    logic [15:0][1:0] exp_port;
  } vec_t;

  function automatic vec_t mk(input int c0, input int c1, input int c2, input int c3, input string s);
    vec_t v;
    v.cnt      = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
    v.exp_n    = 5'(s.len());
    v.exp_port = '0;
    for (int i = 0; i < s.len(); i++) v.exp_port[i] = 2'(s[i] - 8'h30);
    return v;
  endfunction

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    int base, rb, cnt_a, cnt_b, idx;
    int nxt [NP];
    bit ok;
    logic [DW-1:0] d;

    // Words per port, then expected port order of the written words.
    vecs[0] = mk(0, 0, 2, 0, "22");
    vecs[1] = mk(0, 2, 0, 2, "1133");
    vecs[2] = mk(6, 1, 0, 0, "0000100");
    vecs[3] = mk(2, 2, 2, 2, "00112233");
    vecs[4] = mk(1, 0, 0, 5, "033333");
    vecs[5] = mk(0, 9, 0, 0, "111111111");
    vecs[6] = mk(1, 1, 1, 1, "0123");

    reset_n  = 1'b0;
    full     = 1'b0;
    fifo_clr = 1'b1;
    for (int i = 0; i < NP; i++) wr_p[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_read_en", 64'(bus.read_en), 64'd0);
    chk("rst_wen", 64'(bus.wen), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_grant_idx", 64'(bus.grant_idx), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    fifo_clr = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      do_reset();
      base = wl_n;
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < int'(vecs[v].cnt[p]); k++) push(p, word(v, p, k));
      wait_idle($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_nwords", v), 64'(wl_n - base), 64'(vecs[v].exp_n));
      for (int p = 0; p < NP; p++) nxt[p] = 0;
      for (int i = 0; i < int'(vecs[v].exp_n); i++) begin
        idx = int'(vecs[v].exp_port[i]);
        chk($sformatf("vec%0d_w%0d_data", v, i), 64'(wl_data[base+i]), 64'(word(v, idx, nxt[idx])));
        chk($sformatf("vec%0d_w%0d_grant", v, i), 64'(wl_grant[base+i]), 64'(idx));
        nxt[idx]++;
      end
    end

    // Single port: two words, read-to-write latency of two cycles.
    do_reset();
    base = wl_n;
    rb   = re_n;
    push(2, 32'hA1);
    push(2, 32'hA2);
    wait_idle("single");
    chk("single_nreads", 64'(re_n - rb), 64'd2);
    chk("single_rd0_port", 64'(re_port[rb]), 64'd2);
    chk("single_rd1_port", 64'(re_port[rb+1]), 64'd2);
    chk("single_nwrites", 64'(wl_n - base), 64'd2);
    chk("single_w0", 64'(wl_data[base]), 64'hA1);
    chk("single_w1", 64'(wl_data[base+1]), 64'hA2);
    chk("single_latency", 64'(wl_cyc[base] - re_cyc[rb]), 64'd2);

    // Fairness: 10 words on every port, bursts of 4 then 2.
    do_reset();
    base = wl_n;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 10; k++) push(p, word(9, p, k));
    wait_idle("fair");
    chk("fair_nwords", 64'(wl_n - base), 64'd40);
    idx = base;
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < ((r < 2) ? 4 : 2); k++) begin
          chk($sformatf("fair_w%0d", idx - base), 64'(wl_data[idx]), 64'(word(9, p, r*4 + k)));
          idx++;
        end

    // Wrap: grant port 2 so the pointer sits at 3, then ports 3 and 0 compete.
    push(2, word(10, 2, 0));
    wait_idle("wrap_pre");
    base = wl_n;
    push(3, word(10, 3, 0));
    for (int k = 0; k < 3; k++) push(0, word(10, 0, k));
    wait_idle("wrap");
    chk("wrap_nwords", 64'(wl_n - base), 64'd4);
    chk("wrap_w0", 64'(wl_data[base]), 64'(word(10, 3, 0)));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("wrap_w%0d", k + 1), 64'(wl_data[base+1+k]), 64'(word(10, 0, k)));
      chk($sformatf("wrap_g%0d", k + 1), 64'(wl_grant[base+1+k]), 64'd0);
    end
    chk("wrap_grant_end", 64'(bus.grant_idx), 64'd0);
    base = wl_n;
    push(0, word(10, 0, 3));
    push(1, word(10, 1, 0));
    wait_idle("wrap_ptr");
    chk("wrap_ptr_first", 64'(wl_data[base]), 64'(word(10, 1, 0)));
    chk("wrap_ptr_second", 64'(wl_data[base+1]), 64'(word(10, 0, 3)));

    // Backpressure: output full for 5 cycles right after the read strobe.
    d = word(11, 0, 0);
    push(0, d);
    wait_re(0, ok);
    chk("bp_read_seen", 64'(ok), 64'd1);
    full = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      chk($sformatf("bp_wen_c%0d", j), 64'(bus.wen), 64'd0);
      chk($sformatf("bp_re_c%0d", j), 64'(bus.read_en), 64'd0);
    end
    chk("bp_dout_held", 64'(bus.dout), 64'(d));
    full = 1'b0;
    @(negedge clk);
    chk("bp_wen_release", 64'(bus.wen), 64'd1);
    chk("bp_dout_release", 64'(bus.dout), 64'(d));
    cnt_a = 0;
    cnt_b = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.wen) cnt_a++;
      if (|bus.read_en) cnt_b++;
    end
    chk("bp_extra_wen", 64'(cnt_a), 64'd0);
    chk("bp_extra_re", 64'(cnt_b), 64'd0);

    // Asynchronous reset while a fetched word is in flight.
    push(2, word(11, 2, 0));
    wait_re(2, ok);
    chk("rstm_read_seen", 64'(ok), 64'd1);
    @(negedge clk);
    chk("rstm_busy_before", 64'(bus.busy), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rstm_read_en", 64'(bus.read_en), 64'd0);
    chk("rstm_wen", 64'(bus.wen), 64'd0);
    chk("rstm_busy", 64'(bus.busy), 64'd0);
    chk("rstm_grant", 64'(bus.grant_idx), 64'd0);
    chk("rstm_dout", 64'(bus.dout), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.wen) cnt_a++;
      if (|bus.read_en) cnt_b++;
    end
    chk("rstm_no_wen", 64'(cnt_a), 64'd0);
    chk("rstm_no_re", 64'(cnt_b), 64'd0);
    base = wl_n;
    push(0, word(11, 0, 1));
    push(1, word(11, 1, 0));
    wait_idle("rstm_post");
    chk("rstm_ptr_first", 64'(wl_data[base]), 64'(word(11, 0, 1)));
    chk("rstm_ptr_second", 64'(wl_data[base+1]), 64'(word(11, 1, 0)));

    // Output full while idle: nothing issues until it clears.
    do_reset();
    full = 1'b1;
    base = wl_n;
    for (int p = 0; p < NP; p++) push(p, word(12, p, 0));
    cnt_a = 0;
    cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      if (|bus.read_en) cnt_a++;
      if (bus.busy) cnt_b++;
    end
    chk("fullidle_no_re", 64'(cnt_a), 64'd0);
    chk("fullidle_no_busy", 64'(cnt_b), 64'd0);
    full = 1'b0;
    @(negedge clk);
    chk("fullidle_first_re", 64'(bus.read_en), 64'b0001);
    wait_idle("fullidle");
    chk("fullidle_nwords", 64'(wl_n - base), 64'd4);

    chk("read_en_onehot", 64'(onehot_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
